// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for the multicycle RV32I core. Sequences the shared ALU,
//   memory port, IR, PC and register-file writes through the
//   Fetch/Decode/Execute/Memory/Writeback states. It drives ALUOp into the
//   existing ALU decoder, stalls on the mem_ready handshake and flags memory
//   waits that run too long.
//
// Parameters
//   WAIT_LIMIT    max cycles waiting on mem_ready in one memory state (0 = no limit)
//
// Build option
//   ILLEGAL_TRAP_EN  when defined, an unknown opcode parks the FSM in TRAP
//                    with illegal_instr=1 until reset. When undefined, an
//                    unknown opcode is a 2-cycle NOP and illegal_instr is 0.
//
// Ports
//   clk, reset            core clock, synchronous active-high reset
//   op, funct3            IR[6:0], IR[14:12]
//   zero                  ALU zero flag (branch compare)
//   mem_ready             memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc      datapath mux controls
//   mem_timeout           1-cycle pulse when WAIT_LIMIT wait cycles elapse
//   illegal_instr         high while trapped on an illegal opcode
//   state_o               current state encoding (debug)

module multicycle_controller #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       mem_timeout,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int unsigned CNT_W = 16;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   wait_cnt;
    logic               waiting;
    logic               timeout;

    // internal (ungated) strobes
    logic pc_update;
    logic branch;
    logic ir_wr;
    logic mem_wr;
    logic reg_wr;

    // ------------------------------------------------------------------
    // Wait tracking: a cycle in a memory-handshake state without mem_ready.
    // The timeout fires on the WAIT_LIMIT-th consecutive wait cycle, so the
    // counter only has to reach WAIT_LIMIT-1 beforehand.
    // ------------------------------------------------------------------
    always_comb begin
        waiting = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE))
                  && !mem_ready;
        timeout = 1'b0;
        if (WAIT_LIMIT != 0)
            timeout = waiting && ((32'(wait_cnt) + 32'd1) == 32'(WAIT_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (!waiting || timeout)
            wait_cnt <= '0;
        else if (wait_cnt != '1)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_nx;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:    if (mem_ready) state_nx = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nx = MEMADR;
                    OP_RTYPE:          state_nx = EXECR;
                    OP_ITYPE:          state_nx = EXECI;
                    OP_BRANCH:         state_nx = BRANCH;
                    OP_JAL:            state_nx = JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_nx = TRAP;
`else
                    default:           state_nx = FETCH;
`endif
                endcase
            end
            MEMADR:   state_nx = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_nx = MEMWB;
            MEMWB:    state_nx = FETCH;
            MEMWRITE: if (mem_ready) state_nx = FETCH;
            EXECR:    state_nx = ALUWB;
            EXECI:    state_nx = ALUWB;
            ALUWB:    state_nx = FETCH;
            BRANCH:   state_nx = FETCH;
            JAL:      state_nx = ALUWB;
            TRAP:     state_nx = TRAP;
            default:  state_nx = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_wr     = 1'b0;
        mem_wr    = 1'b0;
        reg_wr    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_wr     = mem_ready;
                pc_update = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_wr    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_wr = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                reg_wr = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                // only beq/bne are supported; other funct3 values fall through
                branch  = (funct3[2:1] == 2'b00);
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase

        // Reset masks every write so an aborted instruction leaves no trace.
        PCWrite     = !reset && (pc_update || (branch && (zero ^ funct3[0])));
        IRWrite     = !reset && ir_wr;
        MemWrite    = !reset && mem_wr;
        RegWrite    = !reset && reg_wr;
        mem_timeout = !reset && timeout;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = !reset && (state == TRAP);
`else
        illegal_instr = 1'b0;
`endif
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = OP_R;
    logic [2:0] funct3 = 3'b000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       mem_timeout, illegal_instr;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_controller #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .mem_timeout(mem_timeout),
        .illegal_instr(illegal_instr), .state_o(state_o)
    );

    logic [16:0] got;
    assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUOp, ImmSrc, mem_timeout, illegal_instr};

    // One expected clock cycle of an instruction.
    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic       tmo;
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
    } cyc_t;

    cyc_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_z;

    // Control word the datapath should see in a given state.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic [6:0] o,
                                             input logic [2:0] f3, input logic z,
                                             input logic mr, input logic tmo);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, aop, imm;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
        case (st)
            4'd0:  begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  adr = 1;
            4'd4:  begin res = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin sa = 2'b10; aop = 2'b10; end
            4'd7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            4'd8:  rw = 1;
            4'd9:  begin
                sa = 2'b10; aop = 2'b01;
                if (f3 == 3'b000)      pcw = z;   // beq taken when equal
                else if (f3 == 3'b001) pcw = !z;  // bne taken when different
            end
            4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            4'd11: ill = 1;
            default: ;
        endcase
        if (o == OP_SW)       imm = 2'b01;
        else if (o == OP_BR)  imm = 2'b10;
        else if (o == OP_JAL) imm = 2'b11;
        else                  imm = 2'b00;
        return {pcw, adr, mw, irw, rw, res, sa, sb, aop, imm, tmo, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] g, input logic [31:0] e);
        checks++;
        assert (g === e) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, g, e);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic mr, input logic tmo);
        cyc_t c;
        c.st = st; c.mr = mr; c.tmo = tmo; c.op = cur_op; c.f3 = cur_f3; c.z = cur_z;
        q.push_back(c);
    endtask

    // Non-handshake cycle: mem_ready is irrelevant, so it is randomized.
    task automatic push_any(input logic [3:0] st);
        push(st, 1'($urandom), 1'b0);
    endtask

    // n wait cycles then the ready cycle; with a limit of 4 every 4th wait
    // cycle of a single stall times out.
    task automatic add_wait(input logic [3:0] st, input int n);
        for (int k = 1; k <= n; k++) push(st, 1'b0, (k % 4) == 0);
        push(st, 1'b1, 1'b0);
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            mem_ready = c.mr; op = c.op; funct3 = c.f3; zero = c.z;
            #1;
            check($sformatf("state_s%0d", c.st), 32'(state_o), 32'(c.st));
            check($sformatf("ctrl_s%0d_op%b", c.st, c.op), 32'(got),
                  32'(exp_ctrl(c.st, c.op, c.f3, c.z, c.mr, c.tmo)));
        end
    endtask

    // Expand one instruction into its cycle-by-cycle state trace and run it.
    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                            input int wf, input int wm);
        cur_op = o; cur_f3 = f3; cur_z = z;
        add_wait(4'd0, wf);
        push_any(4'd1);
        case (o)
            OP_LW:  begin push_any(4'd2); add_wait(4'd3, wm); push_any(4'd4); end
            OP_SW:  begin push_any(4'd2); add_wait(4'd5, wm); end
            OP_R:   begin push_any(4'd6); push_any(4'd8); end
            OP_I:   begin push_any(4'd7); push_any(4'd8); end
            OP_BR:  push_any(4'd9);
            OP_JAL: begin push_any(4'd10); push_any(4'd8); end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int k = 0; k < 4; k++) push_any(4'd11);
`endif
            end
        endcase
        run_q();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1; mem_ready = 1'b1;
            #1;
            check("rst_enables",
                  32'({PCWrite, MemWrite, IRWrite, RegWrite, mem_timeout, illegal_instr}), 32'd0);
            if (i > 0) check("rst_state", 32'(state_o), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] o;
        o = OP_BAD;
        for (int k = 0; k < 20; k++) begin
            o = 7'($urandom);
            if (o != OP_LW && o != OP_SW && o != OP_R && o != OP_I &&
                o != OP_BR && o != OP_JAL) break;
            o = OP_BAD;
        end
        return o;
    endfunction

    initial begin
        logic [6:0] o;
        int kind;

        // reset, then first fetch with mem_ready=1 writes IR and PC
        do_reset(3);
        do_instr(OP_R, 3'b000, 1'b0, 0, 0);
        do_instr(OP_LW, 3'b010, 1'b0, 0, 2);
        do_instr(OP_BR, 3'b000, 1'b1, 0, 0);   // beq taken
        do_instr(OP_BR, 3'b000, 1'b0, 0, 0);   // beq not taken
        do_instr(OP_BR, 3'b001, 1'b0, 0, 0);   // bne taken
        do_instr(OP_BR, 3'b001, 1'b1, 0, 0);   // bne not taken
        do_instr(OP_BR, 3'b100, 1'b1, 0, 0);   // unsupported compare falls through
        do_instr(OP_I, 3'b000, 1'b0, 9, 0);    // fetch timeouts on waits 4 and 8
        do_instr(OP_SW, 3'b010, 1'b0, 0, 5);
        do_instr(OP_JAL, 3'b000, 1'b0, 1, 0);

        // abort a store in MEMWRITE: reset must suppress MemWrite
        cur_op = OP_SW; cur_f3 = 3'b010; cur_z = 1'b0;
        add_wait(4'd0, 0); push_any(4'd1); push_any(4'd2);
        run_q();
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        #1;
        check("abort_state", 32'(state_o), 32'd5);
        check("abort_memwrite", 32'(MemWrite), 32'd0);
        do_reset(2);
        do_instr(OP_R, 3'b000, 1'b0, 0, 0);

`ifndef ILLEGAL_TRAP_EN
        do_instr(OP_BAD, 3'b000, 1'b0, 0, 0);
`endif

        for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
            kind = $urandom_range(0, 5);
`else
            kind = $urandom_range(0, 6);
`endif
            case (kind)
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_R;
                3: o = OP_I;
                4: o = OP_BR;
                5: o = OP_JAL;
                default: o = rand_illegal();
            endcase
            do_instr(o, 3'($urandom), 1'($urandom),
                     $urandom_range(0, 9), $urandom_range(0, 9));
        end

`ifdef ILLEGAL_TRAP_EN
        do_instr(OP_BAD, 3'b000, 1'b0, 0, 0);  // traps and stays
        do_reset(2);
        do_instr(OP_R, 3'b000, 1'b0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
